// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Microprogram sequencer that drives an external 8-bit ALU from the issuing
//   side. It holds a host-loaded instruction memory (PROG_DEPTH words of 16
//   bits) and a host-loaded register file (NREGS x 8 bits). A start pulse in
//   IDLE runs the program from PC 0. Each instruction goes through three
//   states:
//     FETCH   - the instruction is fetched.
//     ISSUE   - opcode and operands are presented to the ALU.
//     CAPTURE - the ALU result is written back to the register file.
//   Completion is reported with a one-cycle done pulse.
//
// Instruction word:
//   [15:8] opc    ALU opcode
//   [7:6]  rd     destination register
//   [5:4]  ra     operand A register
//   [3:2]  rb     operand B register
//   [1]    halt   terminate after this instruction
//   [0]    reserved, ignored
//
// Ports:
//   clock       sole clock, rising edge
//   reset       synchronous active-low reset
//   start       begin execution at PC 0 (IDLE only)
//   prog_we     instruction memory write strobe (IDLE only)
//   prog_addr   instruction memory write address
//   prog_data   instruction word to write
//   reg_we      register file host write strobe (IDLE only)
//   reg_addr    register file address for host write and read
//   reg_wdata   host write data
//   reg_rdata   combinational read of reg[reg_addr]
//   alu_opc     opcode to the ALU
//   alu_a       operand A to the ALU
//   alu_b       operand B to the ALU
//   alu_enable  high while an instruction is presented (ISSUE/CAPTURE)
//   alu_z       ALU result
//   busy        high while a program is in progress
//   done        one-cycle pulse when the program terminates
//   pc          current program counter
//   step        single-step resume (only with ALU_SEQ_STEP_EN)
//
// Configuration macro:
//   ALU_SEQ_STEP_EN - adds the step input and a PAUSE state. Each
//                     non-terminating instruction parks in PAUSE until step.
// ============================================================================
module alu_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int NREGS      = 4,
    parameter int PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [15:0]     prog_data,
    input  logic            reg_we,
    input  logic [1:0]      reg_addr,
    input  logic [7:0]      reg_wdata,
    output logic [7:0]      reg_rdata,
    output logic [7:0]      alu_opc,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic            alu_enable,
    input  logic [7:0]      alu_z,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] pc
`ifdef ALU_SEQ_STEP_EN
    ,
    input  logic            step
`endif
);

    // Last executable address; reaching it always terminates the program.
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
`ifdef ALU_SEQ_STEP_EN
        ,
        ST_PAUSE   = 3'd5
`endif
    } state_e;

    typedef struct packed {
        logic [7:0] opc;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       halt;
        logic       rsvd;
    } instr_t;

    state_e          state_q,      state_d;
    logic [PC_W-1:0] pc_q,         pc_d;
    logic [1:0]      ir_rd_q,      ir_rd_d;
    logic            ir_halt_q,    ir_halt_d;
    logic [7:0]      regs_q [0:NREGS-1];
    logic [7:0]      regs_d [0:NREGS-1];
    logic [7:0]      alu_opc_q,    alu_opc_d;
    logic [7:0]      alu_a_q,      alu_a_d;
    logic [7:0]      alu_b_q,      alu_b_d;
    logic            alu_enable_q, alu_enable_d;
    logic            busy_q,       busy_d;
    logic            done_q,       done_d;

    // Instruction memory is deliberately not reset: a program survives reset.
    logic [15:0]     imem_q [0:PROG_DEPTH-1];

    instr_t          fetch_s;
    logic            imem_we_s;
    logic            last_instr_s;
    logic            rsvd_unused_s;

    assign fetch_s       = imem_q[pc_q];
    assign rsvd_unused_s = fetch_s.rsvd;
    assign last_instr_s  = ir_halt_q || (pc_q == PC_LAST);

    // Next-state, datapath and registered-output logic of the sequencer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_rd_d      = ir_rd_q;
        ir_halt_d    = ir_halt_q;
        regs_d       = regs_q;
        alu_opc_d    = alu_opc_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        imem_we_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Both host writes may land in the same cycle.
                if (prog_we) begin
                    imem_we_s = 1'b1;
                end else begin
                    imem_we_s = 1'b0;
                end
                if (reg_we) begin
                    regs_d[reg_addr] = reg_wdata;
                end else begin
                    regs_d[reg_addr] = regs_q[reg_addr];
                end
                if (start) begin
                    pc_d    = {PC_W{1'b0}};
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                // Operands are sampled here, on the edge that enters ISSUE, so
                // they stay stable through ISSUE and CAPTURE even when rd
                // aliases ra or rb.
                ir_rd_d   = fetch_s.rd;
                ir_halt_d = fetch_s.halt;
                alu_opc_d = fetch_s.opc;
                alu_a_d   = regs_q[fetch_s.ra];
                alu_b_d   = regs_q[fetch_s.rb];
                state_d   = ST_ISSUE;
            end

            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                regs_d[ir_rd_q] = alu_z;
                if (last_instr_s) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d = pc_q + PC_W'(1);
`ifdef ALU_SEQ_STEP_EN
                    state_d = ST_PAUSE;
`else
                    state_d = ST_FETCH;
`endif
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

`ifdef ALU_SEQ_STEP_EN
            ST_PAUSE: begin
                if (step) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The ALU is enabled for exactly the ISSUE and CAPTURE cycles.
        alu_enable_d = (state_d == ST_ISSUE) || (state_d == ST_CAPTURE);
        // done is presented the cycle after DONE; busy covers that cycle too
        // so the host never sees done with busy already low.
        done_d       = (state_q == ST_DONE);
        busy_d       = (state_d != ST_IDLE) || (state_q == ST_DONE);
    end

    // State, register file and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= {PC_W{1'b0}};
            ir_rd_q      <= 2'd0;
            ir_halt_q    <= 1'b0;
            alu_opc_q    <= 8'h00;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_rd_q      <= ir_rd_d;
            ir_halt_q    <= ir_halt_d;
            alu_opc_q    <= alu_opc_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_enable_q <= alu_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Instruction memory write port; contents are retained across reset.
    always_ff @(posedge clock) begin
        if (imem_we_s) begin
            imem_q[prog_addr] <= prog_data;
        end
    end

    assign reg_rdata  = regs_q[reg_addr];
    assign alu_opc    = alu_opc_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_enable = alu_enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table-driven single-instruction
// vectors plus hand-written multi-cycle sequences, with expected register
// results queued at stimulus time and popped when done is seen.
module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [15:0] prog_data;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic [7:0] alu_opc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_enable;
    logic [7:0] alu_z;
    logic       busy;
    logic       done;
    logic [3:0] pc;
`ifdef ALU_SEQ_STEP_EN
    logic       step;
`endif

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .alu_opc    (alu_opc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_enable (alu_enable),
        .alu_z      (alu_z),
        .busy       (busy),
        .done       (done),
        .pc         (pc)
`ifdef ALU_SEQ_STEP_EN
        ,
        .step       (step)
`endif
    );

    // Simple ALU stand-in: 20 add, 08 increment, 01 subtract, others xor.
    always_comb begin
        case (alu_opc)
            8'h20:   alu_z = alu_a + alu_b;
            8'h08:   alu_z = alu_a + 8'd1;
            8'h01:   alu_z = alu_a - alu_b;
            default: alu_z = alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        logic [7:0] opc;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] a_val;
        logic [7:0] b_val;
        logic [7:0] exp_z;
    } vec_t;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] val;
    } sb_t;

    vec_t vecs [5];
    sb_t  sb_q [$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;

    always @(negedge clock) begin
        if (done === 1'b1) done_seen++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [7:0] opc, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic halt);
        return {opc, rd, ra, rb, halt, 1'b0};
    endfunction

    task automatic host_wreg(input logic [1:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic host_wprog(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
        reg_addr = a;
        #1;
        v = reg_rdata;
    endtask

    // Leaves the bench 1 ns after the edge that samples start.
    task automatic start_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output int lat);
        lat = base;
        while (done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    task automatic sb_drain();
        sb_t        e;
        logic [7:0] v;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            read_reg(e.addr, v);
            chk($sformatf("sb_r%0d", e.addr), v, e.val);
        end
    endtask

    initial begin
        int         lat;
        int         d0;
        logic [7:0] v;

        vecs[0] = '{8'h20, 2'd1, 2'd2, 2'd1, 8'h03, 8'h05, 8'h08};
        vecs[1] = '{8'h01, 2'd2, 2'd2, 2'd3, 8'h09, 8'h04, 8'h05};
        vecs[2] = '{8'h55, 2'd0, 2'd1, 2'd2, 8'hF0, 8'h3C, 8'hCC};
        vecs[3] = '{8'h20, 2'd3, 2'd0, 2'd1, 8'hFF, 8'h02, 8'h01};
        vecs[4] = '{8'h08, 2'd1, 2'd3, 2'd0, 8'h7F, 8'h00, 8'h80};

        reset = 1'b0; start = 1'b0; prog_we = 1'b0; reg_we = 1'b0;
        prog_addr = 4'd0; prog_data = 16'h0000; reg_addr = 2'd0; reg_wdata = 8'h00;
`ifdef ALU_SEQ_STEP_EN
        step = 1'b0;
`endif
        repeat (3) tick();

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_en", alu_enable, 1'b0);
        chk("rst_opc", alu_opc, 8'h00);
        chk("rst_a", alu_a, 8'h00);
        chk("rst_b", alu_b, 8'h00);
        chk("rst_pc", pc, 4'd0);
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            chk($sformatf("rst_r%0d", i), v, 8'h00);
        end
        reset = 1'b1;
        tick();

        host_wreg(2'd2, 8'hA5);
        read_reg(2'd2, v);
        chk("host_rd", v, 8'hA5);

        // Table-driven single instructions with halt
        for (int i = 0; i < 5; i++) begin
            host_wreg(vecs[i].ra, vecs[i].a_val);
            host_wreg(vecs[i].rb, vecs[i].b_val);
            host_wprog(4'd0, mk(vecs[i].opc, vecs[i].rd, vecs[i].ra, vecs[i].rb, 1'b1));
            sb_q.push_back('{vecs[i].rd, vecs[i].exp_z});
            start_prog();
            tick();
            chk($sformatf("v%0d_issue_en", i), alu_enable, 1'b1);
            chk($sformatf("v%0d_issue_busy", i), busy, 1'b1);
            chk($sformatf("v%0d_issue_opc", i), alu_opc, vecs[i].opc);
            chk($sformatf("v%0d_issue_a", i), alu_a, vecs[i].a_val);
            chk($sformatf("v%0d_issue_b", i), alu_b, vecs[i].b_val);
            tick();
            chk($sformatf("v%0d_cap_en", i), alu_enable, 1'b1);
            chk($sformatf("v%0d_cap_a", i), alu_a, vecs[i].a_val);
            chk($sformatf("v%0d_cap_b", i), alu_b, vecs[i].b_val);
            wait_done(2, lat);
            chk($sformatf("v%0d_done_lat", i), lat, 4);
            chk($sformatf("v%0d_done_pc", i), pc, 4'd0);
            tick();
            chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
            chk($sformatf("v%0d_busy_fall", i), busy, 1'b0);
            chk($sformatf("v%0d_en_off", i), alu_enable, 1'b0);
            sb_drain();
        end

        // No-wrap termination: 16 increments without halt
        host_wreg(2'd0, 8'h00);
        for (int k = 0; k < 16; k++) host_wprog(4'(k), 16'h0800);
        sb_q.push_back('{2'd0, 8'd16});
        start_prog();
        wait_done(0, lat);
        chk("nowrap_lat", lat, 49);
        chk("nowrap_pc", pc, 4'd15);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("nowrap_idle_en", alu_enable, 1'b0);
            chk("nowrap_idle_busy", busy, 1'b0);
        end
        sb_drain();

        // Host writes and start while busy are dropped
        host_wreg(2'd0, 8'h00);
        host_wreg(2'd3, 8'h33);
        for (int k = 0; k < 5; k++) host_wprog(4'(k), 16'h0800);
        host_wprog(4'd5, 16'h0802);
        sb_q.push_back('{2'd0, 8'd6});
        sb_q.push_back('{2'd3, 8'h33});
        d0 = done_seen;
        start_prog();
        tick();
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 16'h0000;
        reg_we = 1'b1; reg_addr = 2'd3; reg_wdata = 8'hAA;
        tick();
        start = 1'b0; prog_we = 1'b0; reg_we = 1'b0;
        wait_done(2, lat);
        chk("busywr_lat", lat, 19);
        repeat (6) tick();
        chk("busywr_busy", busy, 1'b0);
        chk("busywr_single_done", done_seen - d0, 1);
        sb_drain();

        // Reset in the second ISSUE cycle
        host_wreg(2'd0, 8'h40);
        host_wreg(2'd1, 8'h41);
        host_wprog(4'd0, 16'h0800);
        host_wprog(4'd1, 16'h0800);
        host_wprog(4'd2, 16'h0802);
        d0 = done_seen;
        start_prog();
        repeat (4) tick();
        chk("mrst_issue_en", alu_enable, 1'b1);
        chk("mrst_issue_a", alu_a, 8'h41);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_en", alu_enable, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_pc", pc, 4'd0);
        chk("mrst_a", alu_a, 8'h00);
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            chk($sformatf("mrst_r%0d", i), v, 8'h00);
        end
        repeat (5) tick();
        chk("mrst_no_done", done_seen - d0, 0);
        chk("mrst_idle_busy", busy, 1'b0);
        sb_q.push_back('{2'd0, 8'd3});
        start_prog();
        wait_done(0, lat);
        chk("mrst_rerun_lat", lat, 10);
        tick();
        sb_drain();

`ifdef ALU_SEQ_STEP_EN
        // Single-step: park in PAUSE after the first instruction
        host_wreg(2'd0, 8'h00);
        host_wprog(4'd0, 16'h0800);
        host_wprog(4'd1, 16'h0802);
        step = 1'b0;
        start_prog();
        repeat (6) tick();
        chk("pause_busy", busy, 1'b1);
        chk("pause_pc", pc, 4'd1);
        chk("pause_en", alu_enable, 1'b0);
        chk("pause_done", done, 1'b0);
        sb_q.push_back('{2'd0, 8'd2});
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done(0, lat);
        chk("step_done_lat", lat, 4);
        tick();
        sb_drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Microprogram sequencer that drives the 8-bit ALU from the issuing side. Holds a 16-entry instruction memory and a 4-entry 8-bit register file, both host-loaded. On `start` it fetches instructions and drives opcode/operands to the ALU. It writes each ALU result back to the register file and reports completion with a one-cycle `done` pulse.

## Interface
- `PROG_DEPTH`, 16, instruction memory entries; the PC is log2(PROG_DEPTH) bits wide.
- `NREGS`, 4, register file entries; fixed at 4 because the instruction fields are 2 bits.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `start`  in  1  begin execution at PC 0; honoured only in IDLE.
- `prog_we`  in  1  instruction memory write strobe; honoured only in IDLE.
- `prog_addr`  in  4  instruction memory write address.
- `prog_data`  in  16  instruction word.
- `reg_we`  in  1  register file host write strobe; honoured only in IDLE.
- `reg_addr`  in  2  register file address, used for both write and read.
- `reg_wdata`  in  8  host write data.
- `reg_rdata`  out  8  combinational read of reg[`reg_addr`].
- `alu_opc`  out  8  opcode to ALU.
- `alu_a`, `alu_b`  out  8  operands to ALU.
- `alu_enable`  out  1  high while an instruction is presented.
- `alu_z`  in  8  ALU result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the program terminates.
- `pc`  out  4  current program counter.
- `step`  in  1  present only with `ALU_SEQ_STEP_EN` defined.

## Operation
- Instruction word fields:
  - [15:8] opc
  - [7:6] rd
  - [5:4] ra
  - [3:2] rb
  - [1] halt
  - [0] reserved; ignored.
- State machine states: IDLE, FETCH, ISSUE, CAPTURE, DONE.
- IDLE:
  - Host writes are accepted. If `prog_we` and `reg_we` are both high in the same cycle, both writes take effect.
  - `start`=1 sets pc=0 and moves to FETCH.
- FETCH: latch imem[pc] into the instruction register, then go to ISSUE.
- ISSUE:
  - Drive alu_opc=opc, alu_a=reg[ra], alu_b=reg[rb], alu_enable=1.
  - Go to CAPTURE.
- CAPTURE:
  - Outputs are held unchanged.
  - At the closing edge, reg[rd] <= alu_z.
  - If halt=1 or pc=15, go to DONE. Otherwise pc <= pc+1 and go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE.
- The PC never wraps. Executing address 15 always terminates, whether or not its halt bit is set.
- rd may equal ra or rb. Operands are sampled in ISSUE, so the writeback does not disturb them.
- `start`, `prog_we` and `reg_we` are ignored when not in IDLE; writes attempted while busy are dropped.
- alu_opc/alu_a/alu_b keep their last values outside ISSUE/CAPTURE; alu_enable=0 there.
- Reset values:
  - state=IDLE, pc=0, all registers=0.
  - alu_opc/alu_a/alu_b=0, alu_enable=0, busy=0, done=0.
  - Instruction memory is not reset.
- Reset mid-run aborts immediately: no writeback, no `done`.

## Timing
- Each instruction takes 3 cycles: FETCH, ISSUE, CAPTURE.
- The ALU sees stable inputs for 2 full cycles before its result is sampled.
- Program of N instructions: `start` sampled at edge T gives `done` high in cycle T+3N+1, and busy falls at edge T+3N+2.
- `reg_rdata` reflects a host write one cycle after the write edge, and a writeback from the CAPTURE edge onward.
- The earliest a new `start` is accepted is the first IDLE cycle after DONE.

## Configuration
- `ALU_SEQ_STEP_EN` defined:
  - Adds the `step` input and a PAUSE state.
  - A non-terminating CAPTURE goes to PAUSE instead of FETCH, with pc already incremented.
  - PAUSE holds all outputs, keeps busy=1, and moves to FETCH on the cycle `step`=1.
  - Reset exits PAUSE to IDLE.
- `ALU_SEQ_STEP_EN` undefined: no `step` port and no PAUSE state; instructions run back to back.

## Test plan
- Add with halt:
  - Stimulus: load r1=5, r2=3; imem[0]=16'h20_66 (opc 8'h20 add, rd=1, ra=2, rb=1, halt=1); pulse start.
  - Response: alu_opc=8'h20, alu_a=3, alu_b=5 in ISSUE; r1=8; done exactly 4 cycles after the start edge.
- No-wrap termination:
  - Stimulus: 16 instructions, none halted, each opc 8'h08 (a+1) with rd=ra=0, starting from r0=0.
  - Response: r0=16 and pc=15 at done; done in cycle T+49; no further fetch.
- Writes while busy:
  - Stimulus: pulse `start`, `prog_we` and `reg_we` during ISSUE.
  - Response: all three ignored; memory and register contents unchanged; single done.
- Reset mid-run:
  - Stimulus: 3-instruction program; assert reset low in the second ISSUE cycle.
  - Response: next cycle state IDLE, busy=0, all registers 0, alu_enable=0, no done; a later start reruns the program, which is retained.
- Writeback into an operand register:
  - Stimulus: imem[0] = opc 8'h01 (a-b), rd=ra=2, rb=3, halt=1; r2=9, r3=4.
  - Response: r2=5; alu_a stays 9 through CAPTURE.
- `ALU_SEQ_STEP_EN` only:
  - Stimulus: 2-instruction program with step held low.
  - Response: parks in PAUSE with pc=1 and busy=1; a step pulse resumes and done follows 4 cycles after it.
